// File: rtl/dsp_mac_sequencer.sv
// Sequences one dot-product job through an external DSP slice: per-beat operand, opmode and pipeline enables.
// Latency: beat acceptance to opmode is OPM_DLY cycles; last beat to res_valid is LAT+2 cycles; len=0 answers next cycle.
// Backpressure: in_ready is high only in RUN; the result is held in DONE until res_ready, and start is ignored while busy.
module dsp_mac_sequencer #(
    parameter int LAT     = 3,
    parameter int OPM_DLY = 1,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      a_in,
    input  logic [17:0]      b_in,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic             dsp_ceA,
    output logic             dsp_ceB,
    output logic             dsp_ceM,
    output logic             dsp_ceP,
    output logic             dsp_ceOPMODE,
    output logic             dsp_rstP,
    output logic [7:0]       dsp_opmode,
    input  logic [47:0]      dsp_P,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data
);

    localparam int         DRN_W     = $clog2(LAT + 1);
    // X=M, Z=0: first beat starts a fresh sum regardless of what P held before
    localparam logic [7:0] OPM_FIRST = 8'h01;
    // X=M, Z=P: later beats accumulate onto the running sum
    localparam logic [7:0] OPM_ACC   = 8'h09;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   beat_cnt;
    logic [DRN_W-1:0]   drn_cnt;
    logic               first_q;
    logic               rstp_q;
    logic [47:0]        res_q;
    // each stage: {issue flag, opmode}
    logic [8:0]         opm_line [OPM_DLY];

    logic               accept;
    logic               abort_take;

    assign accept     = in_valid && (state == RUN);
    assign abort_take = abort && ((state == RUN) || (state == DRAIN));

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort takes priority over last beat and drain expiry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && (beat_cnt == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (drn_cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state, counters and the opmode delay line
    always_comb begin
        busy         = (state != IDLE);
        in_ready     = (state == RUN);
        dsp_ceA      = accept;
        dsp_ceB      = accept;
        dsp_A        = accept ? a_in : '0;
        dsp_B        = accept ? b_in : '0;
        dsp_ceM      = (state == RUN) || ((state == DRAIN) && (drn_cnt != '0));
        dsp_ceP      = (state == RUN) || ((state == DRAIN) && (drn_cnt != '0));
        dsp_ceOPMODE = opm_line[OPM_DLY-1][8];
        dsp_opmode   = opm_line[OPM_DLY-1][7:0];
        dsp_rstP     = rstp_q;
        res_valid    = (state == DONE);
        res_data     = res_q;
    end

    // Beat and drain counters, first-beat flag, result capture and P-clear pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= '0;
            drn_cnt  <= '0;
            first_q  <= 1'b0;
            rstp_q   <= 1'b1;
            res_q    <= '0;
        end else begin
            rstp_q <= abort_take;
            case (state)
                IDLE: begin
                    if (start) begin
                        beat_cnt <= len;
                        first_q  <= 1'b1;
                        res_q    <= '0;
                    end
                end
                RUN: begin
                    if (accept && !abort) begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                        first_q  <= 1'b0;
                        if (beat_cnt == LEN_W'(1)) begin
                            drn_cnt <= DRN_W'(LAT);
                        end
                    end
                end
                DRAIN: begin
                    if (!abort) begin
                        if (drn_cnt != '0) begin
                            drn_cnt <= drn_cnt - DRN_W'(1);
                        end else begin
                            res_q <= dsp_P;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Opmode delay line aligns each beat's opmode with its product entering the M stage
    always_ff @(posedge clk) begin
        if (!rstn || abort_take) begin
            for (int i = 0; i < OPM_DLY; i++) begin
                opm_line[i] <= '0;
            end
        end else begin
            opm_line[0] <= accept ? {1'b1, (first_q ? OPM_FIRST : OPM_ACC)} : 9'h000;
            for (int i = 1; i < OPM_DLY; i++) begin
                opm_line[i] <= opm_line[i-1];
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP slice (A reg, M reg, OPMODE reg, P accumulator).
// Latency: slice product reaches P three cycles after the operand beat.
// Backpressure: res_ready driven by the stimulus; results are checked against a queue of expected sums.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] a_in = '0;
    logic [17:0] b_in = '0;
    logic [17:0] dsp_A, dsp_B;
    logic        dsp_ceA, dsp_ceB, dsp_ceM, dsp_ceP, dsp_ceOPMODE, dsp_rstP;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_P = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [47:0] res_data;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LAT(3), .OPM_DLY(1), .LEN_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .abort(abort), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_ceA(dsp_ceA), .dsp_ceB(dsp_ceB),
        .dsp_ceM(dsp_ceM), .dsp_ceP(dsp_ceP), .dsp_ceOPMODE(dsp_ceOPMODE),
        .dsp_rstP(dsp_rstP), .dsp_opmode(dsp_opmode), .dsp_P(dsp_P),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Slice model: product token flows A/B reg -> M reg -> P; opmode register loads on ceOPMODE
    logic               s0_v = 1'b0, s1_v = 1'b0;
    logic signed [47:0] s0_p = '0, s1_p = '0;
    logic [7:0]         opm_q = '0;
    logic signed [47:0] ax, bx;
    assign ax = 48'($signed(dsp_A));
    assign bx = 48'($signed(dsp_B));

    always @(posedge clk) begin
        s0_v <= dsp_ceA;
        s0_p <= ax * bx;
        s1_v <= dsp_ceM && s0_v;
        if (dsp_ceM) s1_p <= s0_p;
        if (dsp_ceOPMODE) opm_q <= dsp_opmode;
        if (dsp_rstP) begin
            dsp_P <= '0;
        end else if (dsp_ceP && s1_v) begin
            dsp_P <= (opm_q[3] ? dsp_P : 48'd0) + ((opm_q[1:0] == 2'b01) ? s1_p : 48'sd0);
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [47:0] exp_q[$];

    // Monitor counters, written only by the monitor process
    int          ce_err = 0, opm_cnt = 0, rstp_cnt = 0, spur_cnt = 0;
    logic        acc_prev = 1'b0;
    logic [7:0]  opm_prev = '0;
    logic        drv_first = 1'b0;
    logic        mon_accept;

    always @(posedge clk) begin
        #3;
        mon_accept = in_valid && in_ready;
        if (acc_prev) begin
            if (!dsp_ceOPMODE || dsp_opmode != opm_prev) ce_err++;
        end else if (dsp_ceOPMODE || dsp_opmode != 8'h00) begin
            ce_err++;
        end
        if (mon_accept) begin
            if (!dsp_ceA || !dsp_ceB || dsp_A != a_in || dsp_B != b_in) ce_err++;
        end else if (dsp_ceA || dsp_ceB) begin
            ce_err++;
        end
        if ((!busy || res_valid) && (dsp_ceM || dsp_ceP)) ce_err++;
        if (dsp_ceOPMODE) opm_cnt++;
        if (dsp_rstP) rstp_cnt++;
        if (res_valid && exp_q.size() == 0) spur_cnt++;
        acc_prev = mon_accept && !abort && rstn;
        opm_prev = drv_first ? 8'h01 : 8'h09;
    end

    typedef struct {
        int          len;
        int          a0;
        int          da;
        int          b0;
        int          db;
        int          gap;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Starts a job of v.len beats and drives the first nb of them
    task automatic run_job(input vec_t v, input int nb);
        int k;
        len   = 8'(v.len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            repeat (v.gap) begin
                @(posedge clk); #1;
            end
            a_in      = 18'(v.a0 + i * v.da);
            b_in      = 18'(v.b0 + i * v.db);
            drv_first = (i == 0);
            in_valid  = 1'b1;
            @(negedge clk);
            k = 0;
            while (!in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL beat_accept: in_ready=0 after 20 cycles, want 1");
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_result(input string name, output int waited);
        logic [47:0] e;
        waited = 0;
        @(negedge clk);
        while (!(res_valid && res_ready) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (res_valid && res_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'd0;
            check(name, res_data, e);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: res_valid=0 after 1000 cycles, want 1", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   w, b_ce, b_opm, b_rstp, b_spur, held_err;
        vec_t t;

        vecs[0] = '{4,        1,   2, 2,       2, 0, 48'd100};
        vecs[1] = '{3,       -2,   0, 5,       0, 2, 48'hFFFF_FFFF_FFE2};
        vecs[2] = '{1,        9,   0, 9,       0, 0, 48'd81};
        vecs[3] = '{2,  -131072,   0, -131072, 0, 1, 48'h0008_0000_0000};
        vecs[4] = '{255,      1,   1, 2,       0, 0, 48'd65280};
        vecs[5] = '{6,      100, -50, 3,       1, 1, 48'hFFFF_FFFF_F95C};
        vecs[6] = '{0,        0,   0, 0,       0, 0, 48'd0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_opmode", dsp_opmode, 0);
        check("rst_ceP", dsp_ceP, 0);
        check("rst_rstP", dsp_rstP, 1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_rstP_release", dsp_rstP, 0);
        @(posedge clk); #1;

        // Table-driven jobs
        for (int i = 0; i < 7; i++) begin
            b_ce  = ce_err;
            b_opm = opm_cnt;
            exp_q.push_back(vecs[i].exp);
            run_job(vecs[i], vecs[i].len);
            wait_result($sformatf("job%0d_res", i), w);
            if (vecs[i].len == 0) check("len0_latency", w, 0);
            @(negedge clk);
            check($sformatf("job%0d_idle", i), busy, 0);
            check($sformatf("job%0d_ce", i), ce_err - b_ce, 0);
            check($sformatf("job%0d_opm_cnt", i), opm_cnt - b_opm, vecs[i].len);
            @(posedge clk); #1;
        end

        // Abort after beat 3 of 5, then a fresh single-beat job
        b_rstp = rstp_cnt;
        b_spur = spur_cnt;
        t = '{5, 1, 1, 1, 0, 0, 48'd0};
        run_job(t, 3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 0);
        check("abort_rstP", dsp_rstP, 1);
        @(negedge clk);
        check("abort_rstP_end", dsp_rstP, 0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_rstP_pulses", rstp_cnt - b_rstp, 1);
        check("abort_no_result", spur_cnt - b_spur, 0);
        b_ce = ce_err;
        exp_q.push_back(48'd81);
        t = '{1, 9, 0, 9, 0, 0, 48'd81};
        run_job(t, 1);
        wait_result("after_abort_res", w);
        check("after_abort_ce", ce_err - b_ce, 0);
        @(posedge clk); #1;

        // Result held with res_ready low; start pulse in DONE ignored
        res_ready = 1'b0;
        exp_q.push_back(48'd12);
        t = '{1, 3, 0, 4, 0, 0, 48'd12};
        run_job(t, 1);
        w = 0;
        @(negedge clk);
        while (!res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("hold_valid", res_valid, 1);
        held_err = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            start = (j == 3);
            len   = 8'd2;
            @(negedge clk);
            if (!res_valid || res_data != 48'd12) held_err++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_data", held_err, 0);
        res_ready = 1'b1;
        wait_result("hold_res", w);
        check("hold_handshake_now", w, 0);
        @(negedge clk);
        check("hold_idle_next", busy, 0);
        repeat (3) @(negedge clk);
        check("hold_start_ignored", busy, 0);
        @(posedge clk); #1;

        // Reset during DRAIN
        b_spur = spur_cnt;
        t = '{2, 5, 0, 5, 0, 0, 48'd0};
        run_job(t, 2);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("drain_rst_busy", busy, 0);
        check("drain_rst_valid", res_valid, 0);
        check("drain_rst_in_ready", in_ready, 0);
        check("drain_rst_opmode", {dsp_ceOPMODE, dsp_opmode}, 0);
        check("drain_rst_ceMP", {dsp_ceM, dsp_ceP, dsp_ceA, dsp_ceB}, 0);
        check("drain_rst_res_data", res_data, 0);
        check("drain_rst_rstP", dsp_rstP, 1);
        repeat (10) @(posedge clk);
        #1;
        check("drain_rst_no_result", spur_cnt - b_spur, 0);
        check("ce_total", ce_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameters SHALL be: LAT, 3, cycles from operand beat entering dsp_A/dsp_B to that beat's product reaching dsp_P; OPM_DLY, 1, cycles from beat acceptance to its opmode on dsp_opmode; LEN_W, 8, width of len.
REQ-002 The design SHALL use one clock, clk; reset is synchronous and active-low, port rstn.
REQ-003 Ports SHALL be (name direction width meaning):
  - clk  in  1  clock
  - rstn  in  1  sync active-low reset
  - start  in  1  job request, sampled in IDLE
  - len  in  LEN_W  beat count of job
  - abort  in  1  cancel current job
  - busy  out  1  high in any state but IDLE
  - in_valid  in  1  operand beat valid
  - in_ready  out  1  sequencer accepts beat
  - a_in, b_in  in  18 each  operand pair
  - dsp_A, dsp_B  out  18 each  operands to slice
  - dsp_ceA, dsp_ceB  out  1 each  operand clock enables
  - dsp_ceM, dsp_ceP, dsp_ceOPMODE  out  1 each  pipeline enables
  - dsp_rstP  out  1  active-high P clear to slice
  - dsp_opmode  out  8  slice opmode
  - dsp_P  in  48  slice result
  - res_valid  out  1  dot product available
  - res_ready  in  1  consumer accepts result
  - res_data  out  48  dot product

Function
REQ-004 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-005 IDLE: start=1 with len>0 SHALL load the beat counter with len and enter RUN; start with len=0 SHALL enter DONE with res_data=0.
REQ-006 RUN: in_ready SHALL be 1; a beat is accepted when in_valid&in_ready, and only then SHALL dsp_ceA/dsp_ceB pulse with dsp_A=a_in, dsp_B=b_in.
REQ-007 Without in_valid in RUN, operand enables SHALL be 0 and no opmode change SHALL be issued (bubble tolerated).
REQ-008 On the last accepted beat (counter=1) the FSM SHALL enter DRAIN, load the drain counter with LAT, and drop in_ready the next cycle.
REQ-009 Opmode for beat 1 SHALL be 8'h01 (X=M, Z=0, add, no pre-add); beats 2..len SHALL use 8'h09 (X=M, Z=P feedback, add); outside those slots it SHALL be 8'h00.
REQ-010 Each beat's opmode SHALL appear on dsp_opmode, with dsp_ceOPMODE=1, exactly OPM_DLY cycles after acceptance, through an internal delay line.
REQ-011 dsp_ceM and dsp_ceP SHALL be 1 from RUN entry until the DRAIN counter reaches 0, and 0 in IDLE and DONE so P holds.
REQ-012 DRAIN SHALL decrement once per cycle; at 0 the FSM SHALL capture dsp_P into res_data and enter DONE.
REQ-013 DONE: res_valid SHALL be 1 and res_data stable until res_valid&res_ready, then IDLE next cycle.
REQ-014 start while busy=1 SHALL be ignored; len SHALL be sampled only at job start.
REQ-015 abort in RUN or DRAIN SHALL enter IDLE next cycle, pulse dsp_rstP for 1 cycle, flush the opmode delay line and give no res_valid; abort SHALL win over simultaneous last beat or drain expiry.
REQ-016 abort in DONE or IDLE SHALL be ignored.
REQ-017 len=2^LEN_W-1 SHALL run correctly with no counter wrap.
REQ-018 A job's first beat SHALL NOT depend on any prior P contents; beat-1 opmode Z=0 clears accumulation.

Reset
REQ-019 rstn=0 at a clk edge SHALL force IDLE, clear counters and delay line, set all outputs to 0 (dsp_opmode=8'h00, res_data=0), and assert dsp_rstP for that cycle.
REQ-020 Reset mid-job SHALL discard the job; no res_valid SHALL follow.

Verification
REQ-021 len=4, beats (1,2),(3,4),(5,6),(7,8) back-to-back, slice model LAT=3 -> res_valid with res_data=100, opmode sequence 01,09,09,09.
REQ-022 len=3, in_valid gapped by 2 bubbles per beat, a=-2, b=5 -> res_data=48'hFFFF_FFFF_FFE2 (-30); no opmode issued during bubbles.
REQ-023 len=0 start -> res_valid the next cycle with res_data=0; no dsp_ce* pulses.
REQ-024 len=5, abort after beat 3 -> IDLE next cycle, one dsp_rstP pulse, no res_valid; new job len=1 (9,9) -> 81.
REQ-025 res_ready low 10 cycles in DONE, start pulsed meanwhile -> res_data held, start ignored, IDLE one cycle after res_ready.
REQ-026 rstn low during DRAIN -> all outputs 0 the next cycle, busy=0, no res_valid.
